// File: rtl/nn_rom_pkg.sv
// Shared widths, ROM read latency and FSM state type for the weight streamer.
// Build option: STREAMER_OREG_EN selects a ROM built with its output register
// (two-cycle read latency) instead of the default one-cycle read.
package nn_rom_pkg;

  localparam int WADDR_W = 8;
  localparam int WDATA_W = 16;

`ifdef STREAMER_OREG_EN
  localparam int ROM_LAT = 2;
`else
  localparam int ROM_LAT = 1;
`endif

  // Smallest skid depth that still sustains one word per cycle.
  localparam int DEF_FIFO_DEPTH = ROM_LAT + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } stream_state_e;

endpackage

// File: rtl/wstream_skid_fifo.sv
// Small circular skid FIFO for the weight stream: push/pop/flush, exposes
// occupancy and the head entry. Flush wins over a simultaneous push/pop.
module wstream_skid_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic [DATA_W-1:0]          head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  // Storage write; entries need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rom_weight_streamer.sv
// Streams a contiguous run of weights out of a synchronous-read pROM as a
// valid/ready stream. Reads are issued against credits so the skid FIFO can
// absorb every in-flight word. Build option: STREAMER_OREG_EN (ROM output
// register enabled, two-cycle read latency, rom_oce follows busy).
module rom_weight_streamer
  import nn_rom_pkg::*;
#(
  parameter int ADDR_W     = WADDR_W,
  parameter int DATA_W     = WDATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(ROM_LAT + 1);

  stream_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_W:0]   rem_cnt_q, rem_cnt_d;
  logic [ROM_LAT-1:0] pipe_q, pipe_d;
  logic              done_zero_q, rom_reset_q;
  logic              issue, capture, pop, zero_start, credit_ok;
  logic [ADDR_W-1:0] rom_ad_c;
  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign capture    = pipe_q[ROM_LAT-1];
  assign w_valid    = !fifo_empty;
  assign pop        = w_valid && w_ready;
  assign zero_start = (state_q == IDLE) && start && !abort && (length == '0);

  // Count reads still travelling through the ROM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + INF_W'(pipe_q[i]);
    end
  end

  // A read may issue if every slot it could occupy is free; a pop this cycle
  // returns a slot immediately, which is what keeps the stream at full rate.
  always_comb begin
    int occupancy;
    occupancy = int'(fifo_count) + int'(inflight) - (pop ? 1 : 0);
    credit_ok = (occupancy < FIFO_DEPTH);
  end

  // Next-state, read issue and counter updates. The first read is issued in
  // the same cycle start is accepted to hide one cycle of ROM latency.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    rem_cnt_d   = pop ? rem_cnt_q - 1'b1 : rem_cnt_q;
    issue       = 1'b0;
    rom_ad_c    = addr_q;
    case (state_q)
      IDLE: begin
        if (start && (length != '0)) begin
          issue       = 1'b1;
          rom_ad_c    = base_addr;
          addr_d      = base_addr + 1'b1;
          issue_cnt_d = length - 1'b1;
          rem_cnt_d   = length;
          state_d     = (length == (ADDR_W+1)'(1)) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if ((issue_cnt_q != '0) && credit_ok) begin
          issue       = 1'b1;
          addr_d      = addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q - 1'b1;
          if (issue_cnt_q == (ADDR_W+1)'(1)) state_d = DRAIN;
        end else if (issue_cnt_q == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rem_cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      addr_d      = '0;
      issue_cnt_d = '0;
      rem_cnt_d   = '0;
      issue       = 1'b0;
    end
  end

  // Shift the issue marker through the latency pipe.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = issue;
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // State, counters, latency pipe and single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      rem_cnt_q   <= '0;
      pipe_q      <= '0;
      done_zero_q <= 1'b0;
      rom_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      rem_cnt_q   <= rem_cnt_d;
      pipe_q      <= abort ? '0 : pipe_d;
      done_zero_q <= zero_start;
      rom_reset_q <= abort;
    end
  end

  wstream_skid_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (capture),
    .push_data (rom_dout),
    .pop       (pop),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_zero_q || ((state_q == DRAIN) && (rem_cnt_q == '0) && !abort);
  assign rom_ad    = rom_ad_c;
  assign rom_ce    = issue;
  assign rom_reset = rom_reset_q;
  assign w_data    = w_valid ? fifo_head : '0;
  assign w_last    = w_valid && (rem_cnt_q == (ADDR_W+1)'(1));

`ifdef STREAMER_OREG_EN
  assign rom_oce = busy;
`else
  assign rom_oce = 1'b1;
`endif

endmodule

// File: tb/tb_rom_weight_streamer.sv
// Bench for rom_weight_streamer: behavioural ROM image, a monitor that checks
// every handshake against the address arithmetic of the requested run, a
// table of directed runs, abort/reset sequences and randomized runs.
`timescale 1ns/1ps
module tb_rom_weight_streamer;
  import nn_rom_pkg::*;

  localparam int AW    = WADDR_W;
  localparam int DW    = WDATA_W;
  localparam int DEPTH = DEF_FIFO_DEPTH;
`ifdef STREAMER_OREG_EN
  localparam logic OCE_RST = 1'b0;
`else
  localparam logic OCE_RST = 1'b1;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, w_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, rom_ce, rom_oce, rom_reset, w_valid, w_last;
  logic [AW-1:0] rom_ad;
  logic [DW-1:0] rom_dout, w_data;

  always #5 clk = ~clk;

  rom_weight_streamer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .busy(busy), .done(done), .rom_ad(rom_ad), .rom_ce(rom_ce),
    .rom_oce(rom_oce), .rom_reset(rom_reset), .rom_dout(rom_dout), .w_data(w_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last)
  );

  // Behavioural pROM: synchronous read, optional output register.
  logic [DW-1:0] img [256];
  logic [DW-1:0] rom_r1 = '0, rom_r2 = '0;
  always @(posedge clk) begin
    if (rom_reset) rom_r1 <= '0;
    else if (rom_ce) rom_r1 <= img[rom_ad];
    if (rom_reset) rom_r2 <= '0;
    else if (rom_oce) rom_r2 <= rom_r1;
  end
`ifdef STREAMER_OREG_EN
  assign rom_dout = rom_r2;
`else
  assign rom_dout = rom_r1;
`endif

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Current run description, written by the stimulus, read by the monitor.
  int run_base = 0, run_len = 0, run_hs0 = 0;

  // Monitor state (written only by the monitor).
  int hs_total = 0, done_total = 0, done_cyc = -1, last_hs_cyc = -1;
  int valid_rise_cyc = -1, valid_total = 0, ovf_total = 0, rr_total = 0;
  logic [DW-1:0] first_hs_data = '0, last_hs_data = '0, hold_data = '0;
  logic hold_pending = 1'b0, hold_last = 1'b0, prev_valid = 1'b0;
  logic [AW-1:0] ad_log [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
      prev_valid   = 1'b0;
    end else begin
      int idx;
      if (int'(u_dut.u_fifo.count_q) > DEPTH) ovf_total++;
      if (rom_ce) ad_log.push_back(rom_ad);
      if (rom_reset) rr_total++;
      if (w_valid) valid_total++;
      if (w_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = w_valid;
      if (hold_pending && w_valid) begin
        check("hold_data", 32'(w_data), 32'(hold_data));
        check("hold_last", 32'(w_last), 32'(hold_last));
      end
      hold_pending = w_valid && !w_ready;
      hold_data    = w_data;
      hold_last    = w_last;
      if (w_valid && w_ready) begin
        idx = hs_total - run_hs0;
        hs_total++;
        last_hs_cyc  = cyc;
        last_hs_data = w_data;
        if (idx == 0) first_hs_data = w_data;
        if (idx >= run_len) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got 0x%0h, expected no word (index %0d of %0d)", w_data, idx, run_len);
        end else begin
          check("w_data", 32'(w_data), 32'(img[8'(run_base + idx)]));
          check("w_last", 32'(w_last), 32'(idx == run_len - 1));
        end
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int n);
    case (mode)
      1:       return (n % 2) == 0;
      2:       return $urandom_range(0, 3) != 0;
      3:       return !(n >= 30 && n < 50);
      default: return 1'b1;
    endcase
  endfunction

  // One complete run: start, stream under the chosen ready pattern, then
  // compare the run's totals, ordering and timing with the model.
  task automatic run_stream(input logic [7:0] base, input logic [8:0] len, input int mode);
    int n, limit, s_cyc, hs0, d0, v0, o0, r0, a0, ad_bad;
    hs0 = hs_total; d0 = done_total; v0 = valid_total; o0 = ovf_total; r0 = rr_total;
    a0  = ad_log.size();
    run_base = int'(base); run_len = int'(len); run_hs0 = hs0;
    base_addr = base; length = len; start = 1'b1; w_ready = ready_for(mode, 0);
    s_cyc = cyc;
    tick();
    start = 1'b0;
    n = 1;
    limit = 4 * int'(len) + 100;
    while ((done_total == d0) && (n < limit)) begin
      w_ready = ready_for(mode, n);
      tick();
      n++;
    end
    if (done_total == d0) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after %0d cycles (base 0x%0h length %0d)", n, base, len);
    end
    w_ready = 1'b1;
    repeat (3) tick();
    check("done_count", 32'(done_total - d0), 32'd1);
    check("handshakes", 32'(hs_total - hs0), 32'(len));
    check("rom_reads", 32'(ad_log.size() - a0), 32'(len));
    ad_bad = 0;
    for (int i = a0; i < ad_log.size(); i++) begin
      if (ad_log[i] !== 8'(int'(base) + i - a0)) ad_bad++;
    end
    check("rom_ad_seq", 32'(ad_bad), 32'd0);
    check("fifo_overflow_cycles", 32'(ovf_total - o0), 32'd0);
    check("rom_reset_pulses", 32'(rr_total - r0), 32'd0);
    if (len == '0) begin
      check("zero_len_done_latency", 32'(done_cyc - s_cyc), 32'd1);
      check("zero_len_valid_cycles", 32'(valid_total - v0), 32'd0);
    end else begin
      check("done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);
      if (mode == 0) begin
        check("first_valid_latency", 32'(valid_rise_cyc - s_cyc), 32'(1 + ROM_LAT));
        check("back_to_back", 32'(last_hs_cyc - valid_rise_cyc), 32'(int'(len) - 1));
      end
    end
    $display("run base=0x%02h len=%0d mode=%0d handshakes=%0d done=%0d", base, len, mode,
             hs_total - hs0, done_total - d0);
  endtask

  typedef struct {
    logic [7:0]    base;
    logic [8:0]    len;
    int            mode;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, hs0, d0, r0;
    for (int i = 0; i < 256; i++) img[i] = 16'((i * 263) ^ 16'h3C5A);
    img[0] = 16'h0CC1; img[1] = 16'h0B19; img[2] = 16'h0469; img[3] = 16'h0339;
    img[144] = 16'h0014; img[145] = 16'h00FF; img[146] = 16'h0263;
    img[147] = 16'hFEC0; img[148] = 16'h010B; img[149] = 16'h012A;

    tbl[0] = '{8'h00, 9'd4,   0, 16'h0CC1,    16'h0339};
    tbl[1] = '{8'd144, 9'd6,  1, 16'h0014,    16'h012A};
    tbl[2] = '{8'hFE, 9'd4,   0, img[8'hFE],  img[8'h01]};
    tbl[3] = '{8'hF0, 9'd32,  2, img[8'hF0],  img[8'h0F]};
    tbl[4] = '{8'd5,  9'd0,   0, 16'h0,       16'h0};
    tbl[5] = '{8'd7,  9'd150, 3, img[7],      img[156]};
    tbl[6] = '{8'd0,  9'd256, 0, img[0],      img[255]};

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rom_ad", 32'(rom_ad), 32'd0);
    check("rst_rom_ce", 32'(rom_ce), 32'd0);
    check("rst_rom_oce", 32'(rom_oce), 32'(OCE_RST));
    check("rst_rom_reset", 32'(rom_reset), 32'd0);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_w_data", 32'(w_data), 32'd0);
    check("rst_w_last", 32'(w_last), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      run_stream(tbl[i].base, tbl[i].len, tbl[i].mode);
      if (tbl[i].len != '0) begin
        check("first_word", 32'(first_hs_data), 32'(tbl[i].exp_first));
        check("last_word", 32'(last_hs_data), 32'(tbl[i].exp_last));
      end
    end

    // Abort three cycles into a long run.
    hs0 = hs_total; d0 = done_total; r0 = rr_total;
    run_base = 20; run_len = 100; run_hs0 = hs0;
    base_addr = 8'd20; length = 9'd100; start = 1'b1; w_ready = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_w_valid", 32'(w_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rom_reset", 32'(rom_reset), 32'd1);
    run_len = hs_total - hs0;
    repeat (10) tick();
    check("abort_handshakes", 32'(hs_total - hs0), 32'(3 - ROM_LAT));
    check("abort_no_done", 32'(done_total - d0), 32'd0);
    check("abort_rom_reset_pulses", 32'(rr_total - r0), 32'd1);
    $display("abort at cycle %0d after start: handshakes=%0d", cyc - s, hs_total - hs0);

    // Abort beats a simultaneous start in IDLE.
    d0 = done_total;
    base_addr = 8'd9; length = 9'd5; start = 1'b1; abort = 1'b1;
    #1;
    check("abort_vs_start_rom_ce", 32'(rom_ce), 32'd0);
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_vs_start_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("abort_vs_start_done", 32'(done_total - d0), 32'd0);
    $display("abort with simultaneous start: busy=%0d", busy);

    // New run after abort fetches from the new base.
    run_stream(8'd200, 9'd5, 0);
    check("post_abort_first_word", 32'(first_hs_data), 32'(img[200]));

    // Asynchronous reset in the middle of a run.
    d0 = done_total;
    run_base = 50; run_len = 40; run_hs0 = hs_total;
    base_addr = 8'd50; length = 9'd40; start = 1'b1; w_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_w_valid", 32'(w_valid), 32'd0);
    check("mid_reset_w_data", 32'(w_data), 32'd0);
    check("mid_reset_rom_ce", 32'(rom_ce), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("mid_reset_no_done", 32'(done_total - d0), 32'd0);
    check("mid_reset_idle", 32'(busy), 32'd0);
    $display("async reset mid-run: done pulses=%0d", done_total - d0);

    // Randomized runs with random back-pressure.
    for (int i = 0; i < 6; i++) begin
      run_stream(8'($urandom_range(0, 255)), 9'($urandom_range(1, 48)), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
